// File: rtl/hamming64_pkg.sv
// rtl/hamming64_pkg.sv - shared constants and position-map helpers for the 64-bit Hamming code
package hamming64_pkg;

    localparam int DATA_W  = 64;
    localparam int CHK_W   = 7;
    localparam int MAX_POS = 71;

    function automatic logic is_pow2(input logic [CHK_W-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

    // Data bits occupy the non-power-of-two codeword positions in ascending order.
    function automatic int unsigned data_pos(input int unsigned i);
        int unsigned n;
        int unsigned pos;
        n   = 0;
        pos = 0;
        for (int unsigned p = 1; p <= MAX_POS; p++) begin
            if (!is_pow2(p[CHK_W-1:0])) begin
                n++;
                if (n == i) begin
                    pos = p;
                end
            end
        end
        return pos;
    endfunction

    function automatic logic [DATA_W:1] check_mask(input int k);
        logic [DATA_W:1] m;
        int unsigned     p;
        m = '0;
        for (int i = 1; i <= DATA_W; i++) begin
            p    = data_pos(i);
            m[i] = p[k];
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming64_check_gen.sv
// rtl/hamming64_check_gen.sv - combinational 64-bit to 7-bit Hamming check-bit generator
module hamming64_check_gen
    import hamming64_pkg::*;
(
    input  logic [DATA_W:1]  data_i,
    output logic [CHK_W-1:0] check_o
);

    for (genvar k = 0; k < CHK_W; k++) begin : g_chk
        localparam logic [DATA_W:1] MASK = check_mask(k);
        assign check_o[k] = ^(data_i & MASK);
    end

endmodule

// File: rtl/hamming_decoder_64.sv
// rtl/hamming_decoder_64.sv - two-stage SEC Hamming decoder with handshake and error counters
module hamming_decoder_64
    import hamming64_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:1]   in_data,
    input  logic [CHK_W-1:0]  in_check,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:1]   out_data,
    output logic [CHK_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    logic [CHK_W-1:0] recalc;

    hamming64_check_gen u_check_gen (
        .data_i  (in_data),
        .check_o (recalc)
    );

    logic             s1_valid_q, s1_valid_d;
    logic [DATA_W:1]  s1_data_q, s1_data_d;
    logic [CHK_W-1:0] s1_syn_q, s1_syn_d;
    logic             s2_valid_q, s2_valid_d;
    logic [DATA_W:1]  s2_data_q, s2_data_d;
    logic [CHK_W-1:0] s2_syn_q, s2_syn_d;
    logic             s2_corr_q, s2_corr_d;
    logic             s2_uncorr_q, s2_uncorr_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic             s2_ready;
    logic             out_xfer;
    logic [DATA_W:1]  flip;

    // Only positions 3..71 that hold data can match; check-bit and out-of-range syndromes flip nothing.
    for (genvar i = 1; i <= DATA_W; i++) begin : g_flip
        localparam logic [CHK_W-1:0] POS = CHK_W'(data_pos(i));
        assign flip[i] = (s1_syn_q == POS);
    end

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign out_xfer = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_syn_d     = s1_syn_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_syn_d     = s2_syn_q;
        s2_corr_d    = s2_corr_q;
        s2_uncorr_d  = s2_uncorr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_syn_d  = recalc ^ in_check;
            end
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = s1_data_q ^ flip;
                s2_syn_d    = s1_syn_q;
                s2_corr_d   = (s1_syn_q != '0) && (s1_syn_q <= CHK_W'(MAX_POS));
                s2_uncorr_d = (s1_syn_q > CHK_W'(MAX_POS));
            end
        end

        if (cnt_clear) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (out_xfer && s2_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_xfer && s2_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_syn_q     <= '0;
            s2_corr_q    <= 1'b0;
            s2_uncorr_q  <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_syn_q     <= s2_syn_d;
            s2_corr_q    <= s2_corr_d;
            s2_uncorr_q  <= s2_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid         = s2_valid_q;
    assign out_data          = s2_data_q;
    assign out_syndrome      = s2_syn_q;
    assign out_corrected     = s2_corr_q;
    assign out_uncorrectable = s2_uncorr_q;
    assign corr_count        = corr_cnt_q;
    assign uncorr_count      = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decoder_64.sv
// tb/tb_hamming_decoder_64.sv - directed self-checking bench for hamming_decoder_64
module tb_hamming_decoder_64;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [64:1] in_data;
    logic [6:0]  in_check;
    logic        out_valid;
    logic        out_ready;
    logic [64:1] out_data;
    logic [6:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        cnt_clear;
    logic [3:0]  corr_count;
    logic [3:0]  uncorr_count;

    hamming_decoder_64 #(.CNT_W(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_check          (in_check),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .cnt_clear         (cnt_clear),
        .corr_count        (corr_count),
        .uncorr_count      (uncorr_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: XOR together the positions of all set data bits.
    function automatic logic [6:0] enc(input logic [64:1] d);
        logic [6:0] r;
        int         j;
        r = '0;
        j = 0;
        for (int p = 1; p <= 71; p++) begin
            if ((p & (p - 1)) != 0) begin
                j++;
                if (d[j]) r ^= p[6:0];
            end
        end
        return r;
    endfunction

    task automatic run_one(input logic [64:1] d, input logic [6:0] c,
                           output logic [64:1] od, output logic [6:0] os,
                           output logic oc, output logic ou, output int lat);
        @(negedge clock);
        in_valid  = 1'b1;
        in_data   = d;
        in_check  = c;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        od = out_data;
        os = out_syndrome;
        oc = out_corrected;
        ou = out_uncorrectable;
        @(negedge clock);
    endtask

    logic [64:1] od;
    logic [6:0]  os;
    logic        oc, ou;
    int          lat;

    logic [64:1] s_din [8];
    logic [64:1] s_exp [8];
    logic [6:0]  s_chk [8];
    logic        s_cor [8];
    logic [64:1] w;
    logic [72:0] prev_out;
    logic        stall_prev;
    int          tx, rx, inflight, cyc;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
        in_data = '0; in_check = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_flags", {out_syndrome, out_corrected, out_uncorrectable}, 9'h0);
        check("rst_counts", {corr_count, uncorr_count}, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);

        run_one(64'h0, 7'h00, od, os, oc, ou, lat);
        check("zero_latency", lat, 2);
        check("zero_data", od, 64'h0);
        check("zero_syn", os, 7'h00);
        check("zero_flags", {oc, ou}, 2'b00);
        check("zero_counts", {corr_count, uncorr_count}, 8'h00);

        run_one(64'h0, 7'h03, od, os, oc, ou, lat);
        check("d1_syn", os, 7'd3);
        check("d1_data", od, 64'h1);
        check("d1_flags", {oc, ou}, 2'b10);
        check("d1_corr_count", corr_count, 4'd1);

        run_one(64'h8000_0000_0000_0001, 7'h03, od, os, oc, ou, lat);
        check("d64_syn", os, 7'd71);
        check("d64_data", od, 64'h1);
        check("d64_corr_count", corr_count, 4'd2);

        run_one(64'h1, 7'h43, od, os, oc, ou, lat);
        check("r6_syn", os, 7'd64);
        check("r6_data", od, 64'h1);
        check("r6_flags", {oc, ou}, 2'b10);

        run_one(64'h1, 7'h4B, od, os, oc, ou, lat);
        check("unc_syn", os, 7'd72);
        check("unc_data", od, 64'h1);
        check("unc_flags", {oc, ou}, 2'b01);
        check("unc_counts", {corr_count, uncorr_count}, {4'd3, 4'd1});

        for (int k = 0; k < 8; k++) begin
            w = 64'h0123_4567_89AB_CDEF + 64'(k) * 64'h0101_0101_0101_0101;
            s_exp[k] = w;
            s_chk[k] = enc(w);
            if (k % 2 == 1) w[k * 8 + 1] = ~w[k * 8 + 1];
            s_din[k] = w;
            s_cor[k] = (k % 2 == 1);
        end
        tx = 0; rx = 0; inflight = 0; cyc = 0; stall_prev = 1'b0; prev_out = '0;
        while (rx < 8 && cyc < 100) begin
            @(negedge clock);
            in_valid  = (tx < 8);
            in_data   = s_din[tx % 8];
            in_check  = s_chk[tx % 8];
            out_ready = (cyc % 3 == 0);
            #1;
            check("stream_in_ready", in_ready, !(inflight == 2 && !out_ready));
            if (stall_prev)
                check("stream_stable", {out_data, out_syndrome, out_corrected, out_uncorrectable}, prev_out);
            if (out_valid && out_ready) begin
                check("stream_data", out_data, s_exp[rx % 8]);
                check("stream_corr", out_corrected, s_cor[rx % 8]);
                rx++;
                inflight--;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_data, out_syndrome, out_corrected, out_uncorrectable};
            if (in_valid && in_ready) begin
                tx++;
                inflight++;
            end
            cyc++;
        end
        check("stream_rx", rx, 8);
        check("stream_tx", tx, 8);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("stream_no_dup", out_valid, 1'b0);
        check("stream_corr_count", corr_count, 4'd7);

        cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        #1;
        check("clear_counts", {corr_count, uncorr_count}, 8'h00);

        in_valid = 1'b1; in_data = '0; in_check = 7'h03; out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        check("prio_held_valid", out_valid, 1'b1);
        check("prio_held_count", corr_count, 4'd0);
        out_ready = 1'b1; cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        #1;
        check("prio_clear_wins", corr_count, 4'd0);
        check("prio_drained", out_valid, 1'b0);

        tx = 0; cyc = 0;
        while (tx < 20 && cyc < 100) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = '0; in_check = 7'h03; out_ready = 1'b1;
            #1;
            if (in_ready) tx++;
            cyc++;
        end
        check("sat_sent", tx, 20);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("sat_corr_count", corr_count, 4'd15);
        check("sat_uncorr_count", uncorr_count, 4'd0);

        in_valid = 1'b1; in_data = '0; in_check = 7'h03; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("full_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 64'h0);
        check("mid_rst_flags", {out_syndrome, out_corrected, out_uncorrectable}, 9'h0);
        check("mid_rst_counts", {corr_count, uncorr_count}, 8'h00);
        check("mid_rst_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clock);
        check("mid_rst_discard", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_64.md
Name: hamming_decoder_64

Overview:
Single-error-correcting decoder for the team's 64-data-bit Hamming code (7 check bits, 71-bit codeword).
- Accepts data plus check bits and computes the syndrome.
- Corrects any single-bit error, or flags the word as uncorrectable.
- Sits on the receive/read side of any path protected by the 64-bit check-bit generator.
- Two-stage pipeline with valid/ready handshake on both sides, plus saturating error-event counters.

Parameters:
CNT_W, 16, width of each saturating error counter.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input word valid.
in_ready  out  1  decoder can accept the input word this cycle.
in_data  in  64 [64:1]  received data bits D[1]..D[64].
in_check  in  7 [6:0]  received check bits R[0]..R[6].
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts the output word.
out_data  out  64 [64:1]  corrected data.
out_syndrome  out  7  raw syndrome of this word.
out_corrected  out  1  single-bit error was corrected (data or check bit).
out_uncorrectable  out  1  syndrome is outside 1..71.
cnt_clear  in  1  synchronous clear of both counters.
corr_count  out  CNT_W  number of corrected words.
uncorr_count  out  CNT_W  number of uncorrectable words.

Behaviour:
- Codeword position map (positions 1..71):
  - Check bit R[k] sits at position 2^k.
  - Data bits D[1]..D[64] fill the non-power-of-two positions in ascending order: D[1]=3, D[2]=5, D[3]=6, D[4]=7, D[5]=9, ..., D[57]=63, D[58]=65, ..., D[64]=71.
  - R[k] = XOR of all data bits whose position has bit k set.
- Syndrome: S[k] = R'[k] XOR in_check[k], where R' is recomputed from in_data.
- Classification by S:
  - S=0: no error.
  - S a power of two (1,2,4,...,64): check-bit error; data passed unchanged; out_corrected=1.
  - S in 3..71, not a power of two: flip the data bit at position S; out_corrected=1.
  - S in 72..127: data passed unchanged; out_uncorrectable=1; out_corrected=0.
  - Double errors that alias into 1..71 are miscorrected. No double-error detection is performed; this is a known code limitation.
- Pipeline:
  - Stage 1 registers in_data and S.
  - Stage 2 registers the corrected data and the flags.
  - Latency is 2 cycles from input handshake to out_valid under no backpressure.
  - Throughput is 1 word/cycle.
- Handshake:
  - Input transfer occurs when in_valid and in_ready; output transfer when out_valid and out_ready.
  - A stage advances when its downstream stage is empty or transferring in the same cycle.
  - in_ready = !s1_valid || s1 advances. in_ready is combinational from out_ready; no input-to-output combinational path exists.
  - out_* are stable while out_valid && !out_ready.
  - A new input accepted in the same cycle stage 1 drains must not lose or duplicate a word.
- Counters:
  - corr_count increments by 1 on each output transfer with out_corrected=1.
  - uncorr_count increments by 1 on each output transfer with out_uncorrectable=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear has priority over a simultaneous increment; the result is 0.
- Reset, including mid-operation:
  - Both stage valids clear and in-flight words are discarded.
  - out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0, corr_count=0, uncorr_count=0.
  - in_ready=1 from the first cycle after reset deasserts.

Decomposition:
- Shared package hamming64_pkg:
  - constants DATA_W=64, CHK_W=7, MAX_POS=71.
  - function data_pos(i), returning the codeword position of D[i].
  - function is_pow2(s).
- One sub-module, hamming64_check_gen: combinational 64-bit to 7-bit check-bit generator using the map above. It is instantiated in stage 1 and shared with the encode path, so both ends use one equation set.

Test Plan:
1. in_data=0, in_check=0; out_ready=1 -> two cycles later out_valid=1, out_data=0, out_syndrome=0, flags 0, counters unchanged.
2. Valid codeword for data 64'h0000_0000_0000_0001 with D[1] flipped -> out_syndrome=3, out_data restored, out_corrected=1, corr_count=1.
3. Valid codeword with D[64] flipped -> out_syndrome=71, D[64] restored. Valid codeword with only in_check[6] flipped -> out_syndrome=64, data unchanged, out_corrected=1.
4. Valid codeword with in_check[6] and in_check[3] flipped -> out_syndrome=72, out_uncorrectable=1, out_corrected=0, uncorr_count=1.
5. Stream of 8 back-to-back words with out_ready toggling 1,0,0,1,... -> all 8 words emerge in order, none dropped or duplicated, out_* stable while stalled, in_ready low only while both stages are full and out_ready=0.
6. CNT_W=4: 20 corrected words -> corr_count sticks at 15. Assert cnt_clear together with a corrected transfer -> corr_count=0. Assert reset mid-stream -> out_valid=0 next cycle, counters 0.
